// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder for the data_path load/store port.
// Latency: ready pulses WAIT_CYCLES+1 cycles after the accepting edge. One access is in flight at a time.
// Backpressure: req is accepted only in IDLE. A req raised while busy is ignored, not queued, so the
//   requester holds req until it sees ready. Throughput is one access per WAIT_CYCLES+2 cycles.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-low reset
//   req, we          access request; 1 = store, 0 = load (sampled with req)
//   byte_en[3:0]     store lane enables, bit i -> write_data[8i+7:8i]
//   addr[31:0]       byte address; word 0 lives at BASE_ADDR
//   write_data[31:0] store data
//   read_data[31:0]  load data, valid with ready, 0 otherwise
//   ready            one-cycle response strobe
//   err              out-of-range / misaligned access, valid with ready
//   busy             high from the cycle after acceptance through the response cycle
//
// Optional: define DMEM_CYCLE_COUNTER_EN to map a free-running 32-bit cycle counter
// at byte address 32'hFFFF_FFF0. Loads there read the counter and stores there are ignored.
// If the macro is undefined, that address faults like any other out-of-range access.

module dmem_responder #(
  parameter int          DEPTH       = 64,
  parameter int          ADDR_W      = 6,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  byte_en,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  // Elaboration-time configuration checks
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dmem_responder: WAIT_CYCLES must be in 0..15");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr_w
    $error("dmem_responder: ADDR_W too narrow for DEPTH");
  end

  localparam bit          HAS_WAIT = (WAIT_CYCLES > 0);
  localparam logic [3:0]  CNT_INIT = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  // Request fields captured on acceptance
  logic        lat_we;
  logic [3:0]  lat_be;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Operands of the access currently being decided. With WAIT_CYCLES=0 the
  // store commits on the accepting edge itself, before the latches are loaded.
  // The live inputs are therefore used while in IDLE and the latched copies
  // are used afterwards.
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic              accept;
  logic              enter_resp;
  logic [29:0]       word_off;
  logic              below, over, misal;
  logic              fault;
  logic              wr_en;
  logic [ADDR_W-1:0] idx;
  logic              cyc_hit;
  logic [31:0]       cyc_val;

  logic [31:0] mem [DEPTH];

`ifdef DMEM_CYCLE_COUNTER_EN
  localparam logic [31:0] CYC_ADDR = 32'hFFFF_FFF0;
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign cyc_hit = (cur_addr == CYC_ADDR);
  assign cyc_val = cyc_cnt;
`else
  assign cyc_hit = 1'b0;
  assign cyc_val = '0;
`endif

  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = we;
      cur_be    = byte_en;
      cur_addr  = addr;
      cur_wdata = write_data;
    end else begin
      cur_we    = lat_we;
      cur_be    = lat_be;
      cur_addr  = lat_addr;
      cur_wdata = lat_wdata;
    end
  end

  // Range check is done on word offsets. The two low address bits only matter
  // for the alignment check.
  assign word_off = cur_addr[31:2] - BASE_ADDR[31:2];
  assign below    = (cur_addr < BASE_ADDR);
  assign over     = (word_off >= 30'(DEPTH));
  assign misal    = (cur_addr[1:0] != 2'b00);
  assign fault    = !cyc_hit && (below || over || misal);
  assign idx      = word_off[ADDR_W-1:0];

  assign accept     = (state == ST_IDLE) && req;
  assign enter_resp = (state != ST_RESP) && (state_nx == ST_RESP);
  // Reset gates the write so that a pending access is dropped while reset is held.
  assign wr_en      = reset && enter_resp && cur_we && !fault && !cyc_hit;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (HAS_WAIT) begin
            state_nx = ST_WAIT;
            cnt_nx   = CNT_INIT;
          end else begin
            state_nx = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = ST_RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        // A req seen here is deliberately not accepted.
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      read_data <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ready <= enter_resp;
      err   <= enter_resp && fault;
      busy  <= (state_nx != ST_IDLE);
      // Only a good load drives data. Stores and faults respond with zero.
      if (enter_resp && !cur_we && !fault) begin
        read_data <= cyc_hit ? cyc_val : mem[idx];
      end else begin
        read_data <= '0;
      end
      if (accept) begin
        lat_we    <= we;
        lat_be    <= byte_en;
        lat_addr  <= addr;
        lat_wdata <= write_data;
      end
    end
  end

  // RAM array: contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder. Three instances are used:
// W=1 (base 0), W=0 (base 0x40) and W=3 (base 0).
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [3];
  logic        req_s  [3];
  logic        we_s   [3];
  logic [3:0]  be_s   [3];
  logic [31:0] addr_s [3];
  logic [31:0] wd_s   [3];
  logic [31:0] rd_s   [3];
  logic        rdy_s  [3];
  logic        err_s  [3];
  logic        busy_s [3];

  int          ncmp  = 0;
  int          nfail = 0;
  int unsigned cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(1), .BASE_ADDR(32'h0000_0000)) u_w1 (
    .clk(clk), .reset(rst_n[0]), .req(req_s[0]), .we(we_s[0]), .byte_en(be_s[0]),
    .addr(addr_s[0]), .write_data(wd_s[0]), .read_data(rd_s[0]), .ready(rdy_s[0]),
    .err(err_s[0]), .busy(busy_s[0]));

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(0), .BASE_ADDR(32'h0000_0040)) u_w0 (
    .clk(clk), .reset(rst_n[1]), .req(req_s[1]), .we(we_s[1]), .byte_en(be_s[1]),
    .addr(addr_s[1]), .write_data(wd_s[1]), .read_data(rd_s[1]), .ready(rdy_s[1]),
    .err(err_s[1]), .busy(busy_s[1]));

  dmem_responder #(.DEPTH(64), .ADDR_W(6), .WAIT_CYCLES(3), .BASE_ADDR(32'h0000_0000)) u_w3 (
    .clk(clk), .reset(rst_n[2]), .req(req_s[2]), .we(we_s[2]), .byte_en(be_s[2]),
    .addr(addr_s[2]), .write_data(wd_s[2]), .read_data(rd_s[2]), .ready(rdy_s[2]),
    .err(err_s[2]), .busy(busy_s[2]));

  function automatic int lat_of(input int u);
    case (u)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge while the DUT is idle. Returns the response.
  task automatic acc(input int u, input logic w, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic e, output int lat,
                     output int unsigned acyc);
    req_s[u] = 1'b1; we_s[u] = w; be_s[u] = be; addr_s[u] = a; wd_s[u] = d;
    @(posedge clk); #1;
    acyc = cyc;
    // Scramble the inputs so that the DUT must rely on its latched copy.
    req_s[u] = 1'b0; we_s[u] = ~w; be_s[u] = ~be; addr_s[u] = a ^ 32'h4; wd_s[u] = ~d;
    lat = 0; rd = 'x; e = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk_b("busy_after_accept", busy_s[u], 1'b1);
      if (rdy_s[u] === 1'b1) begin
        lat = k; rd = rd_s[u]; e = err_s[u];
        chk_b("busy_in_resp", busy_s[u], 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    chk_b("ready_drops", rdy_s[u], 1'b0);
    chk_b("busy_drops", busy_s[u], 1'b0);
    chk("rdata_clears", rd_s[u], 32'h0);
  endtask

  task automatic expect_acc(input string tag, input int u, input logic w, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          lat;
    int unsigned ac;
    acc(u, w, be, a, d, rd, e, lat, ac);
    chk({tag, "_lat"}, lat, lat_of(u));
    chk_b({tag, "_err"}, e, exp_err);
    chk({tag, "_rd"}, rd, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_a, rd_b;
    logic        e_a, e_b;
    int          lat_a, lat_b;
    int unsigned cyc_a, cyc_b;
    int          nrdy, npat, nbusy, nrd;

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_s[i] = 1'b0; we_s[i] = 1'b0; be_s[i] = 4'h0;
      addr_s[i] = 32'h0; wd_s[i] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_b("rst_ready", rdy_s[i], 1'b0);
      chk_b("rst_err", err_s[i], 1'b0);
      chk_b("rst_busy", busy_s[i], 1'b0);
      chk("rst_rdata", rd_s[i], 32'h0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;

    // WAIT_CYCLES=1: full, partial and no-op stores
    expect_acc("st_full",  0, 1'b1, 4'hF,    32'h8, 32'hDEADBEEF, 32'h0,        1'b0);
    expect_acc("ld_full",  0, 1'b0, 4'h0,    32'h8, 32'h0,        32'hDEADBEEF, 1'b0);
    expect_acc("st_lane1", 0, 1'b1, 4'b0010, 32'h8, 32'h0000AA00, 32'h0,        1'b0);
    expect_acc("ld_lane1", 0, 1'b0, 4'h0,    32'h8, 32'h0,        32'hDEADAAEF, 1'b0);
    expect_acc("st_be0",   0, 1'b1, 4'h0,    32'h8, 32'hFFFFFFFF, 32'h0,        1'b0);
    expect_acc("ld_be0",   0, 1'b0, 4'h0,    32'h8, 32'h0,        32'hDEADAAEF, 1'b0);
    expect_acc("st_w0",    0, 1'b1, 4'hF,    32'h0, 32'h0BADF00D, 32'h0,        1'b0);
    expect_acc("st_w63",   0, 1'b1, 4'hF,    32'hFC, 32'h63636363, 32'h0,       1'b0);
    expect_acc("ld_w63",   0, 1'b0, 4'h0,    32'hFC, 32'h0,       32'h63636363, 1'b0);
    // Faults, and checks that they leave RAM untouched
    expect_acc("ld_mis",   0, 1'b0, 4'h0,    32'h102, 32'h0,        32'h0, 1'b1);
    expect_acc("ld_oor",   0, 1'b0, 4'h0,    32'h100, 32'h0,        32'h0, 1'b1);
    expect_acc("st_oor",   0, 1'b1, 4'hF,    32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    expect_acc("st_mis",   0, 1'b1, 4'hF,    32'hA,   32'hFFFFFFFF, 32'h0, 1'b1);
    expect_acc("ld_w0",    0, 1'b0, 4'h0,    32'h0,   32'h0, 32'h0BADF00D, 1'b0);
    expect_acc("ld_after_flt", 0, 1'b0, 4'h0, 32'h8,  32'h0, 32'hDEADAAEF, 1'b0);

    // Cycle-counter window
    acc(0, 1'b0, 4'h0, 32'hFFFF_FFF0, 32'h0, rd_a, e_a, lat_a, cyc_a);
    repeat (7) @(posedge clk);
    #1;
    acc(0, 1'b0, 4'h0, 32'hFFFF_FFF0, 32'h0, rd_b, e_b, lat_b, cyc_b);
    chk("cyc_lat_a", lat_a, 2);
    chk("cyc_lat_b", lat_b, 2);
`ifdef DMEM_CYCLE_COUNTER_EN
    chk_b("cyc_err_a", e_a, 1'b0);
    chk_b("cyc_err_b", e_b, 1'b0);
    chk("cyc_delta", rd_b - rd_a, cyc_b - cyc_a);
`else
    chk_b("cyc_err_a", e_a, 1'b1);
    chk_b("cyc_err_b", e_b, 1'b1);
    chk("cyc_rd_a", rd_a, 32'h0);
    chk("cyc_rd_b", rd_b, 32'h0);
`endif

    // WAIT_CYCLES=0, BASE_ADDR=0x40
    expect_acc("b_st",    1, 1'b1, 4'hF, 32'h40,  32'h11223344, 32'h0,        1'b0);
    expect_acc("b_st63",  1, 1'b1, 4'hF, 32'h13C, 32'hA5A5A5A5, 32'h0,        1'b0);
    expect_acc("b_ld63",  1, 1'b0, 4'h0, 32'h13C, 32'h0,        32'hA5A5A5A5, 1'b0);
    expect_acc("b_oor",   1, 1'b0, 4'h0, 32'h140, 32'h0,        32'h0,        1'b1);
    expect_acc("b_below", 1, 1'b0, 4'h0, 32'h3C,  32'h0,        32'h0,        1'b1);

    // req held high for 12 edges: a response every 2nd cycle, 6 in total
    req_s[1] = 1'b1; we_s[1] = 1'b0; be_s[1] = 4'h0; addr_s[1] = 32'h40; wd_s[1] = 32'h0;
    nrdy = 0; npat = 0; nbusy = 0; nrd = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rdy_s[1] === 1'b1) nrdy++;
      if (rdy_s[1] !== ((k % 2) == 1)) npat++;
      if (rdy_s[1] === 1'b1 && busy_s[1] !== 1'b1) nbusy++;
      if (rdy_s[1] === 1'b1 && rd_s[1] !== 32'h11223344) nrd++;
    end
    req_s[1] = 1'b0;
    chk("held_responses", nrdy, 6);
    chk("held_pattern_errs", npat, 0);
    chk("held_busy_gaps", nbusy, 0);
    chk("held_rdata_errs", nrd, 0);
    @(posedge clk); #1;

    // WAIT_CYCLES=3: reset during WAIT aborts the store
    expect_acc("c_st", 2, 1'b1, 4'hF, 32'h4, 32'hCAFEF00D, 32'h0,        1'b0);
    expect_acc("c_ld", 2, 1'b0, 4'h0, 32'h4, 32'h0,        32'hCAFEF00D, 1'b0);
    req_s[2] = 1'b1; we_s[2] = 1'b1; be_s[2] = 4'hF; addr_s[2] = 32'h4; wd_s[2] = 32'h12345678;
    @(posedge clk); #1;
    req_s[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk_b("abort_busy", busy_s[2], 1'b0);
    chk_b("abort_ready", rdy_s[2], 1'b0);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    nrdy = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rdy_s[2] === 1'b1) nrdy++;
    end
    chk("abort_no_ready", nrdy, 0);
    @(posedge clk); #1;
    expect_acc("c_ld_after", 2, 1'b0, 4'h0, 32'h4, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
